// File: rtl/tx_metaframer.sv
// tx_metaframer: lane framing layer. It builds metaframes of META_FRAME_LEN
// words (sync, scrambler state, skip, payload, diagnostic). It emits one
// 64-bit word with a 2-bit sync header per paced slot.
// A rational accumulator issues PACE_NUM slots every PACE_DEN cycles.
//
// Ports
//   USER_CLK         clock, rising edge
//   SYSTEM_RESET     synchronous active-high reset
//   DATA_IN[63:0]    payload word from the burst layer
//   DATA_IN_CTRL     1 = burst control word (header 10), 0 = data (header 01)
//   DATA_IN_VALID    DATA_IN/DATA_IN_CTRL valid
//   DATA_IN_READY    payload word taken this cycle (when also valid)
//   SCRAMBLER_STATE  scrambler state, sampled in the scrambler-state slot
//   LANE_STATUS      diagnostic word bit 33
//   LINK_STATUS      diagnostic word bit 32
//   DATA_OUT[63:0]   framed word
//   HEADER_OUT[1:0]  sync header of DATA_OUT
//   DATA_VALID       new word on DATA_OUT/HEADER_OUT this cycle
//   GEARBOX_VALID    slot tick, one cycle ahead of DATA_VALID
//   FRAME_START      with DATA_VALID when DATA_OUT is the sync word
//
// Slot kind decoded from slot_ctr:
//   state        | meaning
//   SLOT_SYNC    | slot 0, sync word, starts the metaframe
//   SLOT_SCRAM   | slot 1, scrambler state word
//   SLOT_SKIP    | slot 2, skip word
//   SLOT_PAYLOAD | slots 3..LEN-2, user data or idle
//   SLOT_DIAG    | slot LEN-1, diagnostic word (CRC32 field zero)
module tx_metaframer #(
   parameter int META_FRAME_LEN = 16,
   parameter int PACE_NUM       = 64,
   parameter int PACE_DEN       = 67
) (
   input  logic        USER_CLK,
   input  logic        SYSTEM_RESET,
   input  logic [63:0] DATA_IN,
   input  logic        DATA_IN_CTRL,
   input  logic        DATA_IN_VALID,
   output logic        DATA_IN_READY,
   input  logic [57:0] SCRAMBLER_STATE,
   input  logic        LANE_STATUS,
   input  logic        LINK_STATUS,
   output logic [63:0] DATA_OUT,
   output logic [1:0]  HEADER_OUT,
   output logic        DATA_VALID,
   output logic        GEARBOX_VALID,
   output logic        FRAME_START
);

   localparam int ACC_W  = $clog2(PACE_DEN) + 1;
   localparam int SLOT_W = $clog2(META_FRAME_LEN);

   localparam logic [ACC_W-1:0]  NUM       = ACC_W'(PACE_NUM);
   localparam logic [ACC_W-1:0]  DEN       = ACC_W'(PACE_DEN);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(META_FRAME_LEN - 1);
   localparam logic [SLOT_W-1:0] PAY_LAST  = SLOT_W'(META_FRAME_LEN - 2);
   localparam logic [SLOT_W-1:0] PAY_FIRST = SLOT_W'(3);

   localparam logic [63:0] SYNC_WORD = 64'h78F6_78F6_78F6_78F6;
   localparam logic [63:0] SKIP_WORD = 64'h1E1E_1E1E_1E1E_1E1E;
   localparam logic [63:0] IDLE_WORD = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [1:0]  HDR_CTRL  = 2'b10;
   localparam logic [1:0]  HDR_DATA  = 2'b01;

   typedef enum logic [2:0] {
      SLOT_SYNC,
      SLOT_SCRAM,
      SLOT_SKIP,
      SLOT_PAYLOAD,
      SLOT_DIAG
   } slot_kind_e;

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              tick_q, tick_d;
   logic [SLOT_W-1:0] slot_ctr_q, slot_ctr_d;
   logic [63:0]       data_out_q, data_out_d;
   logic [1:0]        header_out_q, header_out_d;
   logic              data_valid_q, data_valid_d;
   logic              frame_start_q, frame_start_d;
   logic [ACC_W-1:0]  acc_sum;
   slot_kind_e        slot_kind;

   always_ff @(posedge USER_CLK) begin
      if (SYSTEM_RESET) begin
         acc_q         <= '0;
         tick_q        <= 1'b0;
         slot_ctr_q    <= '0;
         data_out_q    <= '0;
         header_out_q  <= '0;
         data_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         tick_q        <= tick_d;
         slot_ctr_q    <= slot_ctr_d;
         data_out_q    <= data_out_d;
         header_out_q  <= header_out_d;
         data_valid_q  <= data_valid_d;
         frame_start_q <= frame_start_d;
      end
   end

   // acc stays below PACE_DEN, so acc + PACE_NUM < 2*PACE_DEN fits ACC_W bits.
   always_comb begin
      acc_sum = acc_q + NUM;
      if (acc_sum >= DEN) begin
         acc_d  = acc_sum - DEN;
         tick_d = 1'b1;
      end else begin
         acc_d  = acc_sum;
         tick_d = 1'b0;
      end
   end

   always_comb begin
      slot_kind = SLOT_PAYLOAD;
      if (slot_ctr_q == '0)
         slot_kind = SLOT_SYNC;
      else if (slot_ctr_q == SLOT_W'(1))
         slot_kind = SLOT_SCRAM;
      else if (slot_ctr_q == SLOT_W'(2))
         slot_kind = SLOT_SKIP;
      else if (slot_ctr_q == SLOT_LAST)
         slot_kind = SLOT_DIAG;
   end

   always_comb begin
      data_out_d    = data_out_q;
      header_out_d  = header_out_q;
      data_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      slot_ctr_d    = slot_ctr_q;
      if (tick_q) begin
         data_valid_d = 1'b1;
         slot_ctr_d   = (slot_ctr_q == SLOT_LAST) ? '0 : slot_ctr_q + 1'b1;
         header_out_d = HDR_CTRL;
         case (slot_kind)
            SLOT_SYNC: begin
               data_out_d    = SYNC_WORD;
               frame_start_d = 1'b1;
            end
            SLOT_SCRAM:  data_out_d = {6'b001010, SCRAMBLER_STATE};
            SLOT_SKIP:   data_out_d = SKIP_WORD;
            SLOT_DIAG:   data_out_d = {6'b011001, 24'h0, LANE_STATUS, LINK_STATUS, 32'h0};
            default: begin
               if (DATA_IN_VALID) begin
                  header_out_d = DATA_IN_CTRL ? HDR_CTRL : HDR_DATA;
                  data_out_d   = DATA_IN;
               end else begin
                  data_out_d = IDLE_WORD;
               end
            end
         endcase
      end
   end

   // The range compare doubles as a guard for the slot_kind default branch.
   assign DATA_IN_READY = tick_q && (slot_ctr_q >= PAY_FIRST) && (slot_ctr_q <= PAY_LAST);
   assign GEARBOX_VALID = tick_q;
   assign DATA_OUT      = data_out_q;
   assign HEADER_OUT    = header_out_q;
   assign DATA_VALID    = data_valid_q;
   assign FRAME_START   = frame_start_q;

endmodule

// File: tb/tb_tx_metaframer.sv
module tb_tx_metaframer;

   localparam int MFL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst2;
   logic [63:0] data_in;
   logic        ctrl, vin;
   logic [57:0] scr;
   logic        lane, link;

   logic        ready_a, dv_a, gv_a, fs_a;
   logic [63:0] dout_a;
   logic [1:0]  hout_a;

   logic        ready_b, dv_b, gv_b, fs_b;
   logic [63:0] dout_b;
   logic [1:0]  hout_b;

   tx_metaframer #(.META_FRAME_LEN(MFL), .PACE_NUM(1), .PACE_DEN(1)) dut_a (
      .USER_CLK(clk), .SYSTEM_RESET(rst), .DATA_IN(data_in), .DATA_IN_CTRL(ctrl),
      .DATA_IN_VALID(vin), .DATA_IN_READY(ready_a), .SCRAMBLER_STATE(scr),
      .LANE_STATUS(lane), .LINK_STATUS(link), .DATA_OUT(dout_a), .HEADER_OUT(hout_a),
      .DATA_VALID(dv_a), .GEARBOX_VALID(gv_a), .FRAME_START(fs_a));

   tx_metaframer #(.META_FRAME_LEN(MFL), .PACE_NUM(2), .PACE_DEN(3)) dut_b (
      .USER_CLK(clk), .SYSTEM_RESET(rst2), .DATA_IN(data_in), .DATA_IN_CTRL(ctrl),
      .DATA_IN_VALID(vin), .DATA_IN_READY(ready_b), .SCRAMBLER_STATE(scr),
      .LANE_STATUS(lane), .LINK_STATUS(link), .DATA_OUT(dout_b), .HEADER_OUT(hout_b),
      .DATA_VALID(dv_b), .GEARBOX_VALID(gv_b), .FRAME_START(fs_b));

   typedef struct packed {
      logic [1:0]  hdr;
      logic [63:0] data;
      logic        fs;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic        gv_prev = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] src_cnt;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per presented word.
   always @(posedge clk) begin
      #1;
      if (dv_a) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: DATA_VALID with empty scoreboard, got hdr %b data %h", hout_a, dout_a);
         end else begin
            mon_e = sb_q.pop_front();
            check("header", 66'(hout_a), 66'(mon_e.hdr));
            check("data", 66'(dout_a), 66'(mon_e.data));
            check("frame_start", 66'(fs_a), 66'(mon_e.fs));
            check("gv_before_dv", 66'(gv_prev), 66'(1'b1));
         end
      end
      gv_prev = gv_a;
   end

   // Drives one metaframe slot by slot (tick is high every cycle at pace 1/1).
   // pay_v/pay_c: valid/ctrl per payload slot 3..6; v_other: valid in control slots.
   // abort_at >= 0 pulses reset in place of that slot.
   task automatic run_frame(input logic [3:0] pay_v, input logic [3:0] pay_c, input logic v_other,
                            input logic [57:0] scr_v, input logic ln, input logic lk,
                            input int abort_at);
      int   rdy_cnt;
      exp_t e;
      logic pay;
      rdy_cnt = 0;
      scr  = scr_v;
      lane = ln;
      link = lk;
      for (int s = 0; s < MFL; s++) begin
         if (s == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_data_out", 66'(dout_a), 66'(0));
            check("rst_header_out", 66'(hout_a), 66'(0));
            check("rst_outputs", 66'({dv_a, gv_a, fs_a, ready_a}), 66'(0));
            rst = 1'b0;
            @(negedge clk);
            return;
         end
         pay     = (s >= 3) && (s <= MFL - 2);
         data_in = src_cnt;
         vin     = pay ? pay_v[s-3] : v_other;
         ctrl    = pay ? pay_c[s-3] : 1'b0;
         check($sformatf("ready_slot%0d", s), 66'(ready_a), 66'(pay));
         if (ready_a) rdy_cnt++;
         e.fs  = 1'b0;
         e.hdr = 2'b10;
         case (s)
            0: begin e.data = 64'h78F6_78F6_78F6_78F6; e.fs = 1'b1; end
            1: e.data = 64'h2800_0000_0000_0000 | {6'b0, scr_v};
            2: e.data = 64'h1E1E_1E1E_1E1E_1E1E;
            MFL - 1: e.data = {6'b011001, 24'h0, ln, lk, 32'h0};
            default: begin
               if (vin) begin
                  e.hdr = ctrl ? 2'b10 : 2'b01;
                  e.data = src_cnt;
                  src_cnt = src_cnt + 64'd1;
               end else begin
                  e.data = 64'hAAAA_AAAA_AAAA_AAAA;
               end
            end
         endcase
         sb_q.push_back(e);
         @(negedge clk);
      end
      check("ready_count", 66'(rdy_cnt), 66'(4));
   endtask

   logic [8:0] gv_exp;
   logic [8:0] dv_exp;

   initial begin
      rst = 1'b1; rst2 = 1'b1;
      data_in = '0; ctrl = 1'b0; vin = 1'b0;
      scr = '0; lane = 1'b0; link = 1'b0;
      src_cnt = 64'd1;
      repeat (3) @(negedge clk);

      check("reset_data_out", 66'(dout_a), 66'(0));
      check("reset_header_out", 66'(hout_a), 66'(0));
      check("reset_dv_gv_fs_rdy", 66'({dv_a, gv_a, fs_a, ready_a}), 66'(0));

      // Pace 2/3 pattern, index 0 is the first cycle after release.
      gv_exp = 9'b1_0110_1100;   // bit i = cycle i: 0,0,1,1,0,1,1,0,1
      dv_exp = 9'b0_1101_1000;   // 0,0,0,1,1,0,1,1,0
      rst2 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("pace23_gv_c%0d", i), 66'(gv_b), 66'(gv_exp[i]));
         check($sformatf("pace23_dv_c%0d", i), 66'(dv_b), 66'(dv_exp[i]));
         @(negedge clk);
      end

      rst = 1'b0;
      @(negedge clk);
      // Valid tied high: data 1..4, control slots do not consume.
      run_frame(4'b1111, 4'b0000, 1'b1, 58'h123_4567_89AB_CDEF, 1'b0, 1'b1, -1);
      // No valid: idle words, lane=1 link=0 diagnostic.
      run_frame(4'b0000, 4'b0000, 1'b0, 58'h3FF_0000_FFFF_0001, 1'b1, 1'b0, -1);
      // Control word in slot 3, idle gap in slot 5.
      src_cnt = 64'hC000_0000_0000_0001;
      run_frame(4'b1011, 4'b1001, 1'b1, 58'h0AA_5555_0000_AAAA, 1'b1, 1'b1, -1);
      // Reset in slot 5, then a fresh metaframe must start with sync.
      src_cnt = 64'd100;
      run_frame(4'b1111, 4'b0000, 1'b1, 58'h001_0203_0405_0607, 1'b0, 1'b0, 5);
      run_frame(4'b1111, 4'b0000, 1'b1, 58'h2AB_CDEF_0123_4567, 1'b0, 1'b1, -1);

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 66'(sb_q.size()), 66'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_metaframer.md
# tx_metaframer

Parametrised Interlaken lane framing layer, the successor of the fixed single-lane transmit interface. It builds metaframes of META_FRAME_LEN words (sync, scrambler state, skip, payload, diagnostic) and emits one 64-bit word with a 2-bit header per paced slot. Slot pacing comes from a rational accumulator rather than a hard-coded rotating schedule. It sits between the user/burst layer and the scrambler plus 64b/67b gearbox.

## Interface
- META_FRAME_LEN, 16: words per metaframe; legal range 5..65535.
- PACE_NUM, 64: numerator of the slot rate; 1 <= PACE_NUM <= PACE_DEN.
- PACE_DEN, 67: denominator of the slot rate; the block issues PACE_NUM slots every PACE_DEN cycles.
- USER_CLK  input  1  sole clock; all logic on its rising edge.
- SYSTEM_RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  64  payload word from the burst layer.
- DATA_IN_CTRL  input  1  1 = DATA_IN is a burst control word (header 2'b10); 0 = data word (header 2'b01).
- DATA_IN_VALID  input  1  DATA_IN/DATA_IN_CTRL valid.
- DATA_IN_READY  output  1  block accepts DATA_IN this cycle.
- SCRAMBLER_STATE  input  58  scrambler state, sampled in the scrambler-state slot.
- LANE_STATUS  input  1  diagnostic word bit 33.
- LINK_STATUS  input  1  diagnostic word bit 32.
- DATA_OUT  output  64  framed word.
- HEADER_OUT  output  2  sync header of DATA_OUT.
- DATA_VALID  output  1  DATA_OUT/HEADER_OUT hold a new word this cycle.
- GEARBOX_VALID  output  1  slot tick; high exactly one cycle before each DATA_VALID.
- FRAME_START  output  1  high with DATA_VALID when DATA_OUT is the sync word.

## Operation
- Pacing accumulator acc, width $clog2(PACE_DEN)+1, plus register tick.
  - Each cycle compute n = acc + PACE_NUM.
  - If n >= PACE_DEN: acc <= n - PACE_DEN, tick <= 1.
  - Otherwise: acc <= n, tick <= 0.
  - Reset: acc = 0, tick = 0.
- GEARBOX_VALID = tick.
- Slot counter slot_ctr, width $clog2(META_FRAME_LEN).
  - Advances only on cycles where tick = 1.
  - Wraps from META_FRAME_LEN-1 to 0.
  - Reset value 0.
- Word per slot, loaded into the output registers at the edge where tick = 1:
  - slot 0, sync: header 2'b10, 64'h78F6_78F6_78F6_78F6; FRAME_START <= 1.
  - slot 1, scrambler state: header 2'b10, {6'b001010, SCRAMBLER_STATE}.
  - slot 2, skip: header 2'b10, 64'h1E1E_1E1E_1E1E_1E1E.
  - slots 3..META_FRAME_LEN-2, payload:
    - If DATA_IN_VALID: load {DATA_IN_CTRL ? 2'b10 : 2'b01, DATA_IN}.
    - Otherwise: idle word, header 2'b10, 64'hAAAA_AAAA_AAAA_AAAA.
  - slot META_FRAME_LEN-1, diagnostic: header 2'b10, {6'b011001, 24'h0, LANE_STATUS, LINK_STATUS, 32'h0}. The CRC32 field is zero in this generation.
- DATA_IN_READY = tick && (3 <= slot_ctr <= META_FRAME_LEN-2). It is combinational from registers only and never depends on DATA_IN_VALID.
- A transfer happens only when DATA_IN_READY and DATA_IN_VALID are both high. A word offered outside a payload slot is not consumed; the source holds it.
- On edges where tick = 0: DATA_VALID <= 0, FRAME_START <= 0, and DATA_OUT/HEADER_OUT hold their value.

## Timing
- Reset values:
  - DATA_OUT = 0, HEADER_OUT = 0.
  - DATA_VALID = 0, GEARBOX_VALID = 0, FRAME_START = 0, DATA_IN_READY = 0.
  - acc = 0, slot_ctr = 0.
- Latency: a word accepted at edge k appears on DATA_OUT with DATA_VALID = 1 in cycle k+1. DATA_VALID is tick delayed by one cycle.
- The first word after reset is always the sync word. Reset asserted mid-metaframe abandons that metaframe with no partial completion.
- PACE_NUM = PACE_DEN: tick stays high from the second cycle after reset; one word per cycle.
- The slot_ctr wrap and FRAME_START coincide at each metaframe boundary. Metaframe period in slots is exactly META_FRAME_LEN.
- Simultaneous DATA_IN_VALID and a non-payload slot: the control word wins, DATA_IN is not taken, and READY is 0.
- SCRAMBLER_STATE, LANE_STATUS and LINK_STATUS are sampled only at their slot's tick edge.

## Test plan
- PACE_NUM=2, PACE_DEN=3, reset then 9 cycles free-running -> GEARBOX_VALID = 0,0,1,1,0,1,1,0,1; DATA_VALID is the same sequence shifted one cycle later.
- META_FRAME_LEN=8, PACE 1/1, DATA_IN_VALID tied high with DATA_IN = 64'h1..n -> word sequence per metaframe:
  - sync (FRAME_START=1);
  - 64'h2800_0000_0000_0000 | SCRAMBLER_STATE;
  - skip;
  - four data words with header 01;
  - diagnostic.
  - DATA_IN_READY is high for exactly 4 cycles per 8.
- DATA_IN_VALID low throughout the payload slots -> header 10 and 64'hAAAA_AAAA_AAAA_AAAA in slots 3..META_FRAME_LEN-2.
- DATA_IN_CTRL=1 with DATA_IN = 64'hC000_0000_0000_0001 in a payload slot -> HEADER_OUT = 2'b10 and DATA_OUT unchanged from DATA_IN.
- LANE_STATUS=1, LINK_STATUS=0 -> diagnostic DATA_OUT = 64'h6400_0002_0000_0000.
- SYSTEM_RESET pulsed at slot 5 -> all outputs go to 0 the next cycle; the first DATA_VALID after release carries the sync word.
